// File: rtl/mod_counter.sv
// Up/down modulo-(MAX+1) counter with load, clear, terminal-count and sticky wrap flag.
// Define MOD_COUNTER_SAT_EN to saturate at 0/MAX instead of wrapping (wrapped then stays 0).
module mod_counter #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrapped_q, wrapped_d;
  logic             at_top, at_bot, boundary;

  assign at_top   = (count_q == MAX);
  assign at_bot   = (count_q == '0);
  // A step in the current direction would cross the modulus boundary.
  assign boundary = up ? at_top : at_bot;

  always_comb begin
    count_d   = count_q;
    wrapped_d = wrapped_q;
    if (clr) begin
      count_d   = '0;
      wrapped_d = 1'b0;
    end else if (load) begin
      count_d = (load_val > MAX) ? MAX : load_val;
    end else if (enable) begin
      if (!boundary) begin
        count_d = up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
      end else begin
`ifdef MOD_COUNTER_SAT_EN
        count_d = count_q;
`else
        count_d   = up ? '0 : MAX;
        wrapped_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign count   = count_q;
  assign wrapped = wrapped_q;
  assign tc      = enable & ~clr & ~load & boundary;

endmodule

// File: tb/tb_mod_counter.sv
// Randomised and directed checks of mod_counter against a modular-arithmetic reference model.
module tb_mod_counter;

  localparam int M8 = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr = 0, load = 0, enable = 0, up = 0;
  logic [7:0] load_val = 0;
  logic [7:0] count;
  logic       tc, wrapped;

  logic       clr4 = 0, load4 = 0, enable4 = 0, up4 = 0;
  logic [3:0] load_val4 = 0;
  logic [3:0] count4;
  logic       tc4, wrapped4;

  int checks = 0;
  int failures = 0;
  int mc = 0;
  bit mw = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(8), .MAX(8'd9)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .enable(enable), .up(up), .count(count), .tc(tc), .wrapped(wrapped)
  );

  mod_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr4), .load(load4), .load_val(load_val4),
    .enable(enable4), .up(up4), .count(count4), .tc(tc4), .wrapped(wrapped4)
  );

  function automatic bit model_tc();
    return enable && !clr && !load && (up ? (mc == M8) : (mc == 0));
  endfunction

  task automatic set_in(input bit c, input bit l, input int lv, input bit e, input bit u);
    clr = c; load = l; load_val = lv[7:0]; enable = e; up = u;
  endtask

  // Advance one clock and update the reference model from the sampled inputs.
  task automatic tick();
    bit w;
    @(posedge clk);
    if (clr) begin
      mc = 0; mw = 0;
    end else if (load) begin
      mc = (int'(load_val) > M8) ? M8 : int'(load_val);
    end else if (enable) begin
      w = up ? (mc == M8) : (mc == 0);
`ifdef MOD_COUNTER_SAT_EN
      if (!w) mc = up ? mc + 1 : mc - 1;
`else
      mc = up ? (mc + 1) % (M8 + 1) : (mc + M8) % (M8 + 1);
      if (w) mw = 1;
`endif
    end
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 8'd0 || wrapped !== 1'b0) begin
      failures++;
      $display("FAIL reset_async count=%0d wrapped=%0b required count=0 wrapped=0", count, wrapped);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mc = 0; mw = 0;
    checks++;
    if (count !== 8'd0 || wrapped !== 1'b0 || tc !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold count=%0d wrapped=%0b tc=%0b required 0 0 0", count, wrapped, tc);
    end
  endtask

  task automatic test_wrap_up();
    for (int i = 0; i < 12; i++) begin
      set_in(0, 0, 0, 1, 1);
      #1;
      checks++;
      if (tc !== model_tc()) begin
        failures++;
        $display("FAIL wrap_up_tc cyc=%0d tc=%0b required %0b", i, tc, model_tc());
      end
      tick();
      checks++;
      if (count !== 8'(mc) || wrapped !== mw) begin
        failures++;
        $display("FAIL wrap_up cyc=%0d count=%0d wrapped=%0b required %0d %0b", i, count, wrapped, mc, mw);
      end
    end
  endtask

  task automatic test_load_clamp();
    set_in(0, 1, 200, 1, 1);
    #1;
    checks++;
    if (tc !== 1'b0) begin
      failures++;
      $display("FAIL load_tc tc=%0b required 0", tc);
    end
    tick();
    checks++;
    if (count !== 8'd9 || count !== 8'(mc)) begin
      failures++;
      $display("FAIL load_clamp count=%0d required %0d", count, mc);
    end
    set_in(0, 0, 0, 1, 0);
    tick();
    checks++;
    if (count !== 8'd8 || count !== 8'(mc)) begin
      failures++;
      $display("FAIL load_then_down count=%0d required %0d", count, mc);
    end
  endtask

  task automatic test_down_wrap_clr();
    set_in(1, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 1, 0);
    #1;
    checks++;
    if (tc !== model_tc()) begin
      failures++;
      $display("FAIL down_tc tc=%0b required %0b", tc, model_tc());
    end
    tick();
    checks++;
    if (count !== 8'(mc) || wrapped !== mw) begin
      failures++;
      $display("FAIL down_wrap count=%0d wrapped=%0b required %0d %0b", count, wrapped, mc, mw);
    end
    set_in(1, 1, 5, 1, 1);
    #1;
    checks++;
    if (tc !== 1'b0) begin
      failures++;
      $display("FAIL clr_tc tc=%0b required 0", tc);
    end
    tick();
    checks++;
    if (count !== 8'd0 || wrapped !== 1'b0) begin
      failures++;
      $display("FAIL clr_priority count=%0d wrapped=%0b required 0 0", count, wrapped);
    end
  endtask

  task automatic test_async_reset();
    // Wrap first so the reset has a set sticky flag to clear.
    set_in(0, 0, 0, 1, 0);
    tick();
    set_in(0, 1, 7, 0, 0);
    tick();
    checks++;
    if (count !== 8'(mc) || wrapped !== mw) begin
      failures++;
      $display("FAIL pre_reset count=%0d wrapped=%0b required %0d %0b", count, wrapped, mc, mw);
    end
    set_in(0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 8'd0 || wrapped !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset count=%0d wrapped=%0b required 0 0", count, wrapped);
    end
    #1 rst_n = 1'b1;
    mc = 0; mw = 0;
    set_in(0, 0, 0, 1, 1);
    tick();
    checks++;
    if (count !== 8'd1) begin
      failures++;
      $display("FAIL post_reset count=%0d required 1", count);
    end
  endtask

  task automatic test_boundary_hold();
    set_in(0, 1, 9, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 1, 1);
      #1;
      checks++;
      if (tc !== model_tc()) begin
        failures++;
        $display("FAIL boundary_tc cyc=%0d tc=%0b required %0b", i, tc, model_tc());
      end
      tick();
      checks++;
      if (count !== 8'(mc) || wrapped !== mw) begin
        failures++;
        $display("FAIL boundary cyc=%0d count=%0d wrapped=%0b required %0d %0b", i, count, wrapped, mc, mw);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 10, $urandom_range(0, 255),
             $urandom_range(0, 99) < 75, $urandom_range(0, 1) == 1);
      #1;
      checks++;
      if (tc !== model_tc()) begin
        failures++;
        $display("FAIL random_tc cyc=%0d tc=%0b required %0b", i, tc, model_tc());
      end
      tick();
      checks++;
      if (count !== 8'(mc) || wrapped !== mw) begin
        failures++;
        $display("FAIL random cyc=%0d count=%0d wrapped=%0b required %0d %0b", i, count, wrapped, mc, mw);
      end
    end
    set_in(0, 0, 0, 0, 0);
  endtask

  task automatic test_width4();
    bit [3:0] exp_c;
    bit       exp_w;
    clr4 = 0; load4 = 1; load_val4 = 4'd15; enable4 = 0; up4 = 1;
    tick();
    checks++;
    if (count4 !== 4'd15) begin
      failures++;
      $display("FAIL w4_load count=%0d required 15", count4);
    end
    load4 = 0; enable4 = 1;
    #1;
    checks++;
    if (tc4 !== 1'b1) begin
      failures++;
      $display("FAIL w4_tc tc=%0b required 1", tc4);
    end
    tick();
`ifdef MOD_COUNTER_SAT_EN
    exp_c = 4'd15; exp_w = 1'b0;
`else
    exp_c = 4'd0;  exp_w = 1'b1;
`endif
    checks++;
    if (count4 !== exp_c || wrapped4 !== exp_w) begin
      failures++;
      $display("FAIL w4_rollover count=%0d wrapped=%0b required %0d %0b", count4, wrapped4, exp_c, exp_w);
    end
    enable4 = 0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_load_clamp();
    test_down_wrap_clr();
    test_async_reset();
    test_boundary_hold();
    test_random();
    test_width4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
